// File: rtl/div32_seq.sv
// Iterative restoring divider for DIV/DIVU: one subtract-and-shift step per clock,
// then a sign-fix cycle, presenting quotient (LO) and remainder (HI) with a start/busy/done handshake.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic use_sign);
    if (use_sign && v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic             signed_r;
  logic             dvd_neg_r;
  logic             dvs_neg_r;
  logic             dz_r;
  // dvd_r shifts dividend bits out of the top and quotient bits in at the bottom;
  // on the divide-by-zero path it keeps the raw dividend for the remainder.
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;

  logic [WIDTH-1:0] rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic             borrow_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  // Trial subtraction for one restoring step; borrow is the unsigned-subtract carry.
  always_comb begin
    rem_sh_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
    trial_s  = {1'b0, rem_sh_s} - {1'b0, dvs_r};
    borrow_s = trial_s[WIDTH];
  end

  // Final result selection: divide-by-zero pattern or sign-corrected magnitudes.
  always_comb begin
    q_fix_s = dvd_r;
    r_fix_s = rem_r;
    if (dz_r) begin
      q_fix_s = {WIDTH{1'b1}};
      r_fix_s = dvd_r;
    end else if (signed_r) begin
      q_fix_s = (dvd_neg_r ^ dvs_neg_r) ? negate(dvd_r) : dvd_r;
      r_fix_s = dvd_neg_r ? negate(rem_r) : rem_r;
    end else begin
      q_fix_s = dvd_r;
      r_fix_s = rem_r;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      signed_r    <= 1'b0;
      dvd_neg_r   <= 1'b0;
      dvs_neg_r   <= 1'b0;
      dz_r        <= 1'b0;
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            signed_r  <= is_signed;
            dvd_neg_r <= is_signed & dividend[WIDTH-1];
            dvs_neg_r <= is_signed & divisor[WIDTH-1];
            count_r   <= {CW{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            dvs_r     <= magnitude(divisor, is_signed);
            busy      <= 1'b1;
            if (divisor == {WIDTH{1'b0}}) begin
              dz_r    <= 1'b1;
              dvd_r   <= dividend;
              state_r <= FIX;
            end else begin
              dz_r    <= 1'b0;
              dvd_r   <= magnitude(dividend, is_signed);
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          rem_r   <= borrow_s ? rem_sh_s : trial_s[WIDTH-1:0];
          dvd_r   <= {dvd_r[WIDTH-2:0], ~borrow_s};
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == CW'(WIDTH - 1)) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          quotient    <= q_fix_s;
          remainder   <= r_fix_s;
          div_by_zero <= dz_r;
          done        <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: stimulus pushes reference results, a monitor pops them on done.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div32_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        drop_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        rst_q;
  logic [31:0] hold_q = 32'd0;
  logic [31:0] hold_r = 32'd0;
  logic        hold_dz = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division with the architectural special cases.
  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sb;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        sa  = a;
        sb  = b;
        e.q = sa / sb;
        e.r = sa % sb;
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: on done compare against the scoreboard, otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst_q === 1'b1) begin
      hold_q  = 32'd0;
      hold_r  = 32'd0;
      hold_dz = 1'b0;
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", {32'd0, quotient}, {32'd0, mon_e.q});
        chk("remainder", {32'd0, remainder}, {32'd0, mon_e.r});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dz});
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        hold_q  = mon_e.q;
        hold_r  = mon_e.r;
        hold_dz = mon_e.dz;
      end
    end else if (rst_q !== 1'bx) begin
      chk("held_outputs", {31'd0, quotient, div_by_zero}, {31'd0, hold_q, hold_dz});
      chk("held_remainder", {32'd0, remainder}, {32'd0, hold_r});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    e         = model(s, a, b);
    e.cyc     = cyc + ((b == 32'd0) ? 2 : 34);
    exp_q.push_back(e);
    tick();
    start     = 1'b0;
    is_signed = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  initial begin
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_quotient", {32'd0, quotient}, 64'd0);
    chk("reset_remainder", {32'd0, remainder}, 64'd0);
    chk("reset_dz", {63'd0, div_by_zero}, 64'd0);
    rst = 1'b0;
    tick();

    issue(1'b0, 32'd100, 32'd7);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    issue(1'b0, 32'd5, 32'd0);
    issue(1'b1, 32'hFFFF_FFF6, 32'd0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);

    // start while busy, mid-calculation and during the done cycle, is ignored
    issue(1'b0, 32'd1000, 32'd3);
    repeat (5) tick();
    start = 1'b1; is_signed = 1'b1; dividend = 32'd77; divisor = 32'd0;
    repeat (3) tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    start = 1'b1; dividend = 32'd9; divisor = 32'd4;
    tick();
    start = 1'b0;

    // synchronous reset at cycle 10 of an operation abandons it
    issue(1'b1, $urandom, 32'd13);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    chk("midreset_quotient", {32'd0, quotient}, 64'd0);
    chk("midreset_remainder", {32'd0, remainder}, 64'd0);
    chk("midreset_dz", {63'd0, div_by_zero}, 64'd0);
    drop_e = exp_q.pop_back();
    repeat (40) tick();

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = $urandom_range(1, 255); end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = $urandom_range(0, 100); b = $urandom; end
        default: begin a = $urandom; b = 32'd0 - 32'($urandom_range(1, 20)); end
      endcase
      issue(s, a, b);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
